// File: rtl/conv_window_streamer_pkg.sv
// rtl/conv_window_streamer_pkg.sv - shared constants and FSM state type for the conv window streamer
//
// Purpose: Q8.24 format constants, 3x3 window size and the streamer FSM encoding.
package conv_window_streamer_pkg;

  localparam int          FRAC_BITS = 24;
  localparam logic [31:0] ONE       = 32'h0100_0000;
  localparam int          KWIN      = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOADW,
    S_WIN,
    S_WAIT,
    S_OUT,
    S_GAP,
    S_FIN
  } state_t;

endpackage

// File: rtl/conv_win_addr_gen.sv
// rtl/conv_win_addr_gen.sv - window/tap counters and memory word address for the conv streamer
//
// Purpose: tracks tap k (0..8, split into row kr / column kc) and window origin (r,c).
//          Produces the weight address WBASE+k or the pixel address
//          IBASE+(r+kr)*IMG_W+(c+kc).
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_clr            clear all counters (start of a pass)
//   i_k_step         advance tap k, wrapping 8 -> 0
//   i_win_step       advance window origin in row-major order
//   i_sel_w          1: weight address, 0: pixel address
//   o_addr           memory word address for the current tap
//   o_k_last         current tap is k=8
//   o_win_last       current window is the last one (r=IMG_H-3, c=IMG_W-3)
module conv_win_addr_gen
  import conv_window_streamer_pkg::*;
#(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int ADDR_W = 16,
  parameter int WBASE  = 0,
  parameter int IBASE  = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_clr,
  input  logic              i_k_step,
  input  logic              i_win_step,
  input  logic              i_sel_w,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_k_last,
  output logic              o_win_last
);

  localparam int ROW_W = $clog2(IMG_H);
  localparam int COL_W = $clog2(IMG_W);

  logic [3:0]       r_k;
  logic [1:0]       r_kr;
  logic [1:0]       r_kc;
  logic [ROW_W-1:0] r_r;
  logic [COL_W-1:0] r_c;

  logic [ADDR_W-1:0] w_row;
  logic [ADDR_W-1:0] w_col;
  logic [ADDR_W-1:0] w_pix_addr;
  logic [ADDR_W-1:0] w_wt_addr;

  // kr/kc run alongside k so the pixel address needs no divide by 3.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) begin
      r_k  <= '0;
      r_kr <= '0;
      r_kc <= '0;
      r_r  <= '0;
      r_c  <= '0;
    end else begin
      if (i_k_step) begin
        if (o_k_last) begin
          r_k  <= '0;
          r_kr <= '0;
          r_kc <= '0;
        end else begin
          r_k <= r_k + 4'd1;
          if (r_kc == 2'd2) begin
            r_kc <= '0;
            r_kr <= r_kr + 2'd1;
          end else begin
            r_kc <= r_kc + 2'd1;
          end
        end
      end
      if (i_win_step) begin
        if (r_c == COL_W'(IMG_W - 3)) begin
          r_c <= '0;
          r_r <= r_r + ROW_W'(1);
        end else begin
          r_c <= r_c + COL_W'(1);
        end
      end
    end
  end

  assign w_row      = ADDR_W'(r_r) + ADDR_W'(r_kr);
  assign w_col      = ADDR_W'(r_c) + ADDR_W'(r_kc);
  assign w_pix_addr = ADDR_W'(IBASE) + w_row * ADDR_W'(IMG_W) + w_col;
  assign w_wt_addr  = ADDR_W'(WBASE) + ADDR_W'(r_k);

  assign o_addr     = i_sel_w ? w_wt_addr : w_pix_addr;
  assign o_k_last   = (r_k == 4'(KWIN - 1));
  assign o_win_last = (r_r == ROW_W'(IMG_H - 3)) && (r_c == COL_W'(IMG_W - 3));

endmodule

// File: rtl/conv_window_streamer.sv
// rtl/conv_window_streamer.sv - streams 3x3 weights and image windows to the conv accelerator
//
// Purpose: loads 9 weights once per pass, then for every valid 3x3 window streams
//          its 9 pixels, captures the accelerator result and hands it downstream.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   start / busy / done     pass control and status
//   mem_rd_en, mem_addr     word memory read request (data back one cycle later)
//   mem_rd_data             memory read data
//   acc_data, acc_valid,    accelerator stream: word, valid, weight(1)/pixel(0) select
//   acc_filter
//   acc_result              accelerator result, valid ACC_LAT cycles after 9th pixel
//   res_data, res_valid,    per-window result handshake
//   res_ready
module conv_window_streamer
  import conv_window_streamer_pkg::*;
#(
  parameter int IMG_W   = 8,
  parameter int IMG_H   = 8,
  parameter int ADDR_W  = 16,
  parameter int WBASE   = 0,
  parameter int IBASE   = 16,
  parameter int ACC_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rd_data,
  output logic [31:0]       acc_data,
  output logic              acc_valid,
  output logic              acc_filter,
  input  logic [31:0]       acc_result,
  output logic [31:0]       res_data,
  output logic              res_valid,
  input  logic              res_ready
);

  state_t      r_state;
  logic        r_busy;
  logic        r_done;
  logic        r_rd_en;
  logic        r_sel_w;
  logic        r_acc_valid;
  logic        r_acc_filter;
  logic [31:0] r_res_data;
  logic        r_res_valid;
  logic [7:0]  r_lat_cnt;

  logic              w_clr;
  logic              w_win_step;
  logic              w_k_last;
  logic              w_win_last;
  logic [ADDR_W-1:0] w_addr;

  assign w_clr      = (r_state == S_IDLE) && start;
  assign w_win_step = (r_state == S_GAP) && !w_win_last;

  conv_win_addr_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W),
    .WBASE  (WBASE),
    .IBASE  (IBASE)
  ) u_addr_gen (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_clr      (w_clr),
    .i_k_step   (r_rd_en),
    .i_win_step (w_win_step),
    .i_sel_w    (r_sel_w),
    .o_addr     (w_addr),
    .o_k_last   (w_k_last),
    .o_win_last (w_win_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_rd_en      <= 1'b0;
      r_sel_w      <= 1'b0;
      r_acc_valid  <= 1'b0;
      r_acc_filter <= 1'b0;
      r_res_data   <= '0;
      r_res_valid  <= 1'b0;
      r_lat_cnt    <= '0;
    end else begin
      // Read data returns one cycle after the strobe, so the accelerator
      // qualifiers are the read strobe/select delayed by one cycle.
      r_acc_valid  <= r_rd_en;
      r_acc_filter <= r_rd_en & r_sel_w;
      r_done       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_LOADW;
            r_busy  <= 1'b1;
            r_rd_en <= 1'b1;
            r_sel_w <= 1'b1;
          end
        end
        S_LOADW: begin
          // Reads continue straight into the first window with no bubble.
          if (w_k_last) begin
            r_state <= S_WIN;
            r_sel_w <= 1'b0;
          end
        end
        S_WIN: begin
          if (w_k_last) begin
            r_state   <= S_WAIT;
            r_rd_en   <= 1'b0;
            r_lat_cnt <= '0;
          end
        end
        S_WAIT: begin
          // First WAIT cycle is the one presenting the 9th pixel word.
          if (r_lat_cnt == 8'(ACC_LAT)) begin
            r_res_data  <= acc_result;
            r_res_valid <= 1'b1;
            r_state     <= S_OUT;
          end else begin
            r_lat_cnt <= r_lat_cnt + 8'd1;
          end
        end
        S_OUT: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= S_GAP;
          end
        end
        S_GAP: begin
          if (w_win_last) begin
            r_state <= S_FIN;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_WIN;
            r_rd_en <= 1'b1;
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign mem_rd_en  = r_rd_en;
  assign mem_addr   = r_rd_en ? w_addr : '0;
  assign acc_data   = r_acc_valid ? mem_rd_data : '0;
  assign acc_valid  = r_acc_valid;
  assign acc_filter = r_acc_filter;
  assign res_data   = r_res_data;
  assign res_valid  = r_res_valid;

endmodule

// File: tb/tb_conv_window_streamer.sv
// tb/tb_conv_window_streamer.sv - directed self-checking bench for conv_window_streamer
module tb_conv_window_streamer;
  import conv_window_streamer_pkg::*;

  localparam int IW = 4;
  localparam int IH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, mem_rd_en;
  logic [15:0] mem_addr;
  logic [31:0] mem_rd_data = '0;
  logic [31:0] acc_data;
  logic        acc_valid, acc_filter;
  logic [31:0] acc_result = '0;
  logic [31:0] res_data;
  logic        res_valid;
  logic        res_ready = 1'b1;

  int checks = 0;
  int errors = 0;

  conv_window_streamer #(
    .IMG_W(IW), .IMG_H(IH), .ADDR_W(16), .WBASE(0), .IBASE(16), .ACC_LAT(1)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .acc_data(acc_data), .acc_valid(acc_valid), .acc_filter(acc_filter),
    .acc_result(acc_result), .res_data(res_data), .res_valid(res_valid),
    .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  // Word memory: data one cycle after the read strobe.
  logic [31:0] mem [32];
  always @(posedge clk) mem_rd_data <= mem_rd_en ? mem[mem_addr[4:0]] : 32'h0;

  // Accelerator model: 9 weights, then 9-pixel Q8.24 MAC, result one cycle after 9th pixel.
  logic signed [31:0] mw [9];
  int     mwc = 0;
  int     mpc = 0;
  longint macc = 0;

  function automatic longint mulq(input logic signed [31:0] a, input logic signed [31:0] b);
    return longint'(a) * longint'(b);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      mwc <= 0; mpc <= 0; macc <= 0; acc_result <= '0;
    end else if (acc_valid) begin
      if (acc_filter) begin
        mw[mwc] <= acc_data;
        mwc <= (mwc == 8) ? 0 : mwc + 1;
      end else if (mpc == 8) begin
        acc_result <= 32'((macc + mulq(mw[mpc], acc_data)) >>> FRAC_BITS);
        macc <= 0; mpc <= 0;
      end else begin
        macc <= macc + mulq(mw[mpc], acc_data);
        mpc <= mpc + 1;
      end
    end
  end

  // Stream monitor, sampled on the falling edge.
  logic [31:0] res_q [$];
  logic [15:0] addr_q [$];
  int          run_q [$];
  int done_cnt = 0, filt_cnt = 0, pix_cnt = 0, run_len = 0;
  int order_err = 0, stall_err = 0;
  logic last_pix = 1'b0, held = 1'b0;
  logic [31:0] held_data = '0;

  always @(negedge clk) begin
    if (res_valid && res_ready) res_q.push_back(res_data);
    if (done) done_cnt <= done_cnt + 1;
    if (mem_rd_en) addr_q.push_back(mem_addr);
    if (acc_valid) begin
      run_len <= run_len + 1;
      if (acc_filter) begin
        filt_cnt <= filt_cnt + 1;
        if (last_pix) order_err <= order_err + 1;
      end else begin
        pix_cnt  <= pix_cnt + 1;
        last_pix <= 1'b1;
      end
    end else if (run_len != 0) begin
      run_q.push_back(run_len);
      run_len <= 0;
    end
    if (!busy) last_pix <= 1'b0;
    if (res_valid && !res_ready) begin
      if (mem_rd_en || acc_valid) stall_err <= stall_err + 1;
      if (held && res_data != held_data) stall_err <= stall_err + 1;
      held <= 1'b1;
      held_data <= res_data;
    end else begin
      held <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    step(1);
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int base);
    for (int i = 0; i < 500 && done_cnt == base; i++) step(1);
  endtask

  function automatic logic [95:0] all_outs();
    return 96'({busy, done, mem_rd_en, mem_addr, acc_data, acc_valid, acc_filter,
                res_data, res_valid});
  endfunction

  int rb, db, ab, qb, fb, pb, ob, sb;
  logic [31:0] d0;
  logic [31:0] exp_id [4];

  initial begin
    exp_id[0] = 32'h0500_0000; exp_id[1] = 32'h0600_0000;
    exp_id[2] = 32'h0900_0000; exp_id[3] = 32'h0A00_0000;
    for (int i = 0; i < 32; i++) mem[i] = ONE;

    // Reset state
    step(3);
    reset = 1'b0;
    step(1);
    chk("reset_outputs", all_outs(), 96'h0);

    // Pass 1: all weights and pixels 1.0
    rb = res_q.size(); db = done_cnt; ab = addr_q.size(); qb = run_q.size();
    fb = filt_cnt; pb = pix_cnt; ob = order_err;
    pulse_start();
    chk("p1_busy", busy, 1);
    chk("p1_first_rd", {mem_rd_en, mem_addr}, {1'b1, 16'd0});
    chk("p1_no_acc_yet", acc_valid, 0);
    step(1);
    chk("p1_first_word", {acc_valid, acc_filter, acc_data}, {1'b1, 1'b1, ONE});
    wait_done(db);
    chk("p1_done_cnt", done_cnt - db, 1);
    chk("p1_busy_after", {busy, done}, 2'b00);
    chk("p1_nres", res_q.size() - rb, 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("p1_res%0d", i), res_q[rb + i], 32'h0900_0000);
    chk("p1_addr_px0", addr_q[ab + 9], 16'd16);
    chk("p1_addr_px8", addr_q[ab + 17], 16'd26);
    chk("p1_addr_w1_px0", addr_q[ab + 18], 16'd17);
    chk("p1_nruns", run_q.size() - qb, 4);
    chk("p1_run0", run_q[qb], 18);
    for (int i = 1; i < 4; i++) chk($sformatf("p1_run%0d", i), run_q[qb + i], 9);
    chk("p1_filt_words", filt_cnt - fb, 9);
    chk("p1_pix_words", pix_cnt - pb, 36);
    chk("p1_order", order_err - ob, 0);

    // Pass 2: identity kernel, pixel i = i<<24, stall on result 2
    for (int i = 0; i < 9; i++) mem[i] = (i == 4) ? ONE : 32'h0;
    for (int i = 0; i < 16; i++) mem[16 + i] = 32'(i) << 24;
    rb = res_q.size(); db = done_cnt; sb = stall_err;
    pulse_start();
    for (int i = 0; i < 300 && res_q.size() == rb; i++) step(1);
    res_ready = 1'b0;
    for (int i = 0; i < 300 && !res_valid; i++) step(1);
    chk("p2_stall_valid", res_valid, 1);
    d0 = res_data;
    step(5);
    chk("p2_stall_held", {res_valid, res_data}, {1'b1, d0});
    chk("p2_stall_quiet", {mem_rd_en, acc_valid}, 2'b00);
    res_ready = 1'b1;
    wait_done(db);
    chk("p2_done_cnt", done_cnt - db, 1);
    chk("p2_nres", res_q.size() - rb, 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("p2_res%0d", i), res_q[rb + i], exp_id[i]);
    chk("p2_stall_err", stall_err - sb, 0);

    // Reset in the 5th pixel cycle of window 1
    db = done_cnt; pb = pix_cnt;
    pulse_start();
    for (int i = 0; i < 300 && pix_cnt - pb < 13; i++) step(1);
    chk("abort_in_win1", {busy, acc_valid, acc_filter}, 3'b110);
    reset = 1'b1;
    step(1);
    chk("abort_outputs", all_outs(), 96'h0);
    reset = 1'b0;
    step(2);
    chk("abort_no_done", done_cnt - db, 0);
    rb = res_q.size();
    pulse_start();
    wait_done(db);
    chk("abort_restart_done", done_cnt - db, 1);
    chk("abort_restart_nres", res_q.size() - rb, 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("abort_res%0d", i), res_q[rb + i], exp_id[i]);

    // start pulsed while busy is ignored
    rb = res_q.size(); db = done_cnt;
    pulse_start();
    step(10);
    pulse_start();
    wait_done(db);
    step(30);
    chk("rebusy_done_cnt", done_cnt - db, 1);
    chk("rebusy_nres", res_q.size() - rb, 4);
    chk("rebusy_idle", {busy, mem_rd_en}, 2'b00);

    // start together with reset: reset wins
    reset = 1'b1;
    start = 1'b1;
    step(1);
    reset = 1'b0;
    start = 1'b0;
    step(2);
    chk("start_with_reset", {busy, mem_rd_en, acc_valid}, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
